// File: rtl/sram_bist_pkg.sv
// Shared constants, FSM states and march phase encoding for the SRAM self-test engine.
package sram_bist_pkg;

  localparam logic [1:0] MODE_ACOMP  = 2'd0;
  localparam logic [1:0] MODE_CHK    = 2'd1;
  localparam logic [1:0] MODE_MARCH  = 2'd2;
  localparam logic [1:0] MODE_VERIFY = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    INJ_REQ,
    INJ_WAIT,
    DONE
  } state_t;

  // PH_R0W1 reads zeros and writes ones at each address before stepping.
  typedef enum logic [1:0] {
    PH_W0,
    PH_R0W1,
    PH_R1
  } phase_t;

endpackage

// File: rtl/sram_bist_patgen.sv
// Combinational test-pattern generator: expected read word and write word for (mode, phase, address).
module sram_bist_patgen
  import sram_bist_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic [1:0]    mode,
  input  phase_t        phase,
  input  logic [AW-1:0] a,
  output logic [DW-1:0] exp_dat,
  output logic [DW-1:0] wr_dat
);

  logic [DW-1:0] chk;

  always_comb begin
    chk = '0;
    // Odd addresses get 0101..., even addresses 1010...
    for (int i = 0; i < DW; i++) begin
      chk[i] = a[0] ^ i[0];
    end

    exp_dat = ~DW'(a);
    wr_dat  = ~DW'(a);
    case (mode)
      MODE_CHK: begin
        exp_dat = chk;
        wr_dat  = chk;
      end
      MODE_MARCH: begin
        exp_dat = (phase == PH_R1) ? {DW{1'b1}} : {DW{1'b0}};
        wr_dat  = (phase == PH_W0) ? {DW{1'b0}} : {DW{1'b1}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_bist.sv
// SRAM self-test engine driving sram_ctrl requests; one request per ready window,
// first mem pulse two cycles after start, stalls in *_REQ/*_WAIT while ready is low.
module sram_bist
  import sram_bist_pkg::*;
#(
  parameter int AW    = 18,
  parameter int DW    = 16,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             inject,
  input  logic [AW-1:0]    inj_addr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [AW-1:0]    fail_addr,
  output logic             fail_valid,
  output logic [7:0]       inj_cnt,
  input  logic             ready,
  input  logic [DW-1:0]    data_s2f,
  output logic             mem,
  output logic             rw,
  output logic [AW-1:0]    addr,
  output logic [DW-1:0]    data_f2s
);

  localparam logic [AW-1:0] TOP = '1;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          issue, issue_rw, cmp, clr, inj_done, fin;
  logic [DW-1:0] issue_wdat;
  logic [DW-1:0] exp_dat, wr_dat;
  logic          mismatch;

  sram_bist_patgen #(.AW(AW), .DW(DW)) u_patgen (
    .mode    (mode_q),
    .phase   (phase_q),
    .a       (cnt_q),
    .exp_dat (exp_dat),
    .wr_dat  (wr_dat)
  );

  assign busy     = (state_q != IDLE);
  assign mismatch = (data_s2f != exp_dat);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    issue_rw   = 1'b1;
    issue_wdat = wr_dat;
    cmp        = 1'b0;
    clr        = 1'b0;
    inj_done   = 1'b0;
    fin        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          mode_d  = mode;
          phase_d = PH_W0;
          cnt_d   = '0;
          state_d = (mode == MODE_VERIFY) ? RD_REQ : WR_REQ;
        end else if (inject) begin
          cnt_d   = inj_addr;
          state_d = INJ_REQ;
        end
      end
      WR_REQ: begin
        if (ready) begin
          issue    = 1'b1;
          issue_rw = 1'b0;
          state_d  = WR_WAIT;
        end
      end
      RD_REQ: begin
        if (ready) begin
          issue   = 1'b1;
          state_d = RD_WAIT;
        end
      end
      INJ_REQ: begin
        issue_wdat = '1;
        if (ready) begin
          issue    = 1'b1;
          issue_rw = 1'b0;
          state_d  = INJ_WAIT;
        end
      end
      // ready is still high while our own mem pulse is out, so that cycle never completes an access.
      WR_WAIT: begin
        if (!mem && ready) begin
          if (mode_q == MODE_MARCH && phase_q == PH_R0W1) begin
            state_d = RD_REQ;
            if (cnt_q == TOP) phase_d = PH_R1;
            else              cnt_d   = cnt_q + AW'(1);
          end else if (cnt_q == TOP) begin
            cnt_d   = '0;
            state_d = RD_REQ;
            if (mode_q == MODE_MARCH) phase_d = PH_R0W1;
          end else begin
            cnt_d   = cnt_q + AW'(1);
            state_d = WR_REQ;
          end
        end
      end
      RD_WAIT: begin
        if (!mem && ready) begin
          cmp = 1'b1;
          if (mode_q == MODE_MARCH && phase_q == PH_R0W1) begin
            state_d = WR_REQ;
          end else if (mode_q == MODE_MARCH) begin
            if (cnt_q == '0) state_d = DONE;
            else begin
              cnt_d   = cnt_q - AW'(1);
              state_d = RD_REQ;
            end
          end else if (cnt_q == TOP) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + AW'(1);
            state_d = RD_REQ;
          end
        end
      end
      INJ_WAIT: begin
        if (!mem && ready) begin
          inj_done = 1'b1;
          state_d  = IDLE;
        end
      end
      DONE: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= PH_W0;
      mode_q     <= MODE_ACOMP;
      cnt_q      <= '0;
      mem        <= 1'b0;
      rw         <= 1'b1;
      addr       <= '0;
      data_f2s   <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_addr  <= '0;
      fail_valid <= 1'b0;
      inj_cnt    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      mem     <= issue;
      if (issue) begin
        rw       <= issue_rw;
        addr     <= cnt_q;
        data_f2s <= issue_wdat;
      end
      done <= fin;
      if (clr) begin
        err_cnt    <= '0;
        fail_valid <= 1'b0;
        pass       <= 1'b0;
      end else if (cmp && mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        if (!fail_valid) begin
          fail_addr  <= cnt_q;
          fail_valid <= 1'b1;
        end
      end
      if (fin) pass <= (err_cnt == '0);
      if (inj_done) inj_cnt <= inj_cnt + 8'd1;
    end
  end

endmodule

// File: doc/sram_bist.md
# sram_bist

Parametrised built-in self-test engine for the external asynchronous SRAM. It sits between the board-level test logic (buttons, switches, LEDs, seven-segment display) and the existing `sram_ctrl` unit, and drives the controller's `mem`/`rw`/`addr`/`data_f2s` request interface. It sweeps the whole address space with a selectable data pattern and counts read-back mismatches, capturing the first failing address. It also injects single-word faults on request.

## Interface
- `AW`, default 18: SRAM address width; test space is 0 .. 2^AW-1.
- `DW`, default 16: SRAM data width.
- `ERR_W`, default 16: width of the error counter.
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a test in the selected `mode`.
- `mode`  in  2  0 address-complement, 1 checkerboard, 2 march, 3 verify-only.
- `inject`  in  1  one-cycle pulse; writes all-ones to `inj_addr`.
- `inj_addr`  in  AW  fault-injection address.
- `busy`  out  1  high from the cycle after an accepted `start`/`inject` until the engine returns to IDLE.
- `done`  out  1  one-cycle pulse at the end of a test (not after injection).
- `pass`  out  1  `err_cnt == 0` at the last `done`; held until the next `start`.
- `err_cnt`  out  ERR_W  mismatch count; saturates at all-ones.
- `fail_addr`  out  AW  address of the first mismatch of the current test.
- `fail_valid`  out  1  `fail_addr` holds a captured address.
- `inj_cnt`  out  8  number of accepted injections; wraps at 8 bits.
- `ready`  in  1  from `sram_ctrl`; high when the controller is idle and will accept a request.
- `data_s2f`  in  DW  registered read data from `sram_ctrl`.
- `mem`  out  1  request strobe to `sram_ctrl`; pulse lasts one cycle.
- `rw`  out  1  1 = read, 0 = write.
- `addr`  out  AW  request address.
- `data_f2s`  out  DW  write data.

## Operation
- **Pattern P(a)**, where `a` is the address:
  - Mode 0 and mode 3: P(a) = ~a. The address is zero-extended or truncated to DW bits.
  - Mode 1: P(a) = a[0] ? 0101… : 1010…
  - Mode 2: all-zeros or all-ones words, depending on the phase.
- **Test sequence by mode**:
  - Modes 0 and 1: a write pass from 0 up to the top address, then a read/compare pass over the same range.
  - Mode 3: the read/compare pass only, using the mode 0 pattern. It checks a previous fill plus any injected faults.
  - Mode 2 (march), three phases:
    - Phase 0: W0 ascending.
    - Phase 1: R0 then W1 at each address, ascending.
    - Phase 2: R1 descending, from the top address down to 0.
- **States**: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, INJ_REQ, INJ_WAIT, DONE.
- **Transitions**:
  - IDLE:
    - `start` → clear `err_cnt`, `fail_valid` and `pass`; load the address counter (0, or the top address for a descending pass); go to the first request state.
    - `inject` → INJ_REQ.
  - *_REQ: wait until `ready`=1, then pulse `mem` for one cycle → *_WAIT.
  - RD_WAIT: the first cycle with `ready`=1 samples `data_s2f` and compares it with the expected word.
  - WR_WAIT: exits on `ready`=1.
  - End of a pass: step the address. Move to the next pass or phase when the counter wraps (ascending) or reaches 0 (descending); otherwise go back to a REQ state.
  - The last pass completes → DONE, which pulses `done` for one cycle → IDLE.
  - INJ_WAIT with `ready`=1 → IDLE, and `inj_cnt` += 1.
- **On mismatch**: `err_cnt` += 1, saturating. If `fail_valid`=0, capture the address into `fail_addr` and set `fail_valid`.
- **Boundary rules**:
  - `start` or `inject` while busy: ignored.
  - `start` and `inject` in the same IDLE cycle: `start` wins and the injection is dropped.
  - Changes on `mode` or `inj_addr` are sampled only on acceptance; changes while busy have no effect.
  - Reset mid-test takes effect immediately (asynchronous):
    - all state → IDLE;
    - all outputs return to their reset values, so no partial `mem` pulse is produced.
  - Reset values:
    - `mem`=0, `rw`=1;
    - `addr`, `data_f2s`, `err_cnt`, `fail_addr` and `inj_cnt` = 0;
    - `busy`, `done`, `pass` and `fail_valid` = 0.

## Timing
- Registered outputs: `mem`, `rw`, `addr` and `data_f2s` are registered. `mem`=1 always comes with `rw`/`addr`/`data_f2s` valid in the same cycle.
- The earliest `mem` pulse is 2 cycles after `start` is sampled.
- Requests are issued only while `ready`=1. `mem` is never high on two consecutive cycles.
- Throughput is bounded by `sram_ctrl`, never by this block. The block adds at most 1 idle cycle between a `ready` return and the next request.
- `err_cnt`, `fail_addr` and `fail_valid` update on the cycle after the compare.
- `done` and `pass` assert together, as the final update of a test.

## Structure
- Package `sram_bist_pkg`:
  - mode constants (MODE_ACOMP, MODE_CHK, MODE_MARCH, MODE_VERIFY);
  - state enumeration;
  - march phase encoding.
- Sub-module `sram_bist_patgen`: combinational pattern function taking (mode, phase, address) and returning expected/write data, parametrised by AW and DW.

## Test plan
All directed tests run with AW=4, DW=16, a behavioural `sram_ctrl` model (ready low for 2 cycles per access) and a 16-word memory model.
- **Mode 0**: `start` → 16 writes of ~a, then 16 reads; `done` pulse, `pass`=1, `err_cnt`=0, `inj_cnt`=0.
- **Injection then verify**: after a mode 0 run, `inject` with `inj_addr`=5, then `start` in mode 3 → `inj_cnt`=1, `err_cnt`=1, `fail_addr`=5, `fail_valid`=1, `pass`=0.
- **March with stuck bit**: memory model has bit 3 stuck at 0 at address 9; mode 2 → `err_cnt`=1, and the error is seen in phase 2 (R1 descending), `fail_addr`=9.
- **Saturation**: ERR_W=3, memory returns 0 for all reads, mode 1 → `err_cnt` saturates at 7; `fail_addr`=0 (address 0 expects 1010… and reads 0, so it is the first mismatch).
- **Reset mid-test**: assert `reset_n`=0 during the mode 0 write pass → same cycle: `mem`=0, `busy`=0, counters 0. After release, a fresh `start` completes with `pass`=1.
- **Collisions**: `start` and `inject` in the same cycle → the test runs and `inj_cnt` is unchanged. `start` pulsed while busy → no restart, exactly one `done`.
